// File: rtl/mux_pipe_n.sv
// mux_pipe_n: selects one of N = 2**SELW input channels per accepted request
// and queues the captured data/select in a 2-entry skid buffer.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   flush          - synchronous discard of all buffered entries
//   in_valid/in_ready, sel, din   - request side (din packs N channels)
//   out_valid/out_ready, dout, out_sel - head entry of the buffer
//   count          - entries held (0..2)
module mux_pipe_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SELW  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SELW-1:0]           sel,
  input  logic [(2**SELW)*WIDTH-1:0] din,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          dout,
  output logic [SELW-1:0]           out_sel,
  output logic [1:0]                count
);

  localparam int unsigned N = 2**SELW;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] skid_data;
  logic [SELW-1:0]  skid_sel;
  logic [WIDTH-1:0] new_data;
  logic             accept;
  logic             transfer;

  // Handshakes decoded straight from the state register, so in_ready never
  // depends on out_ready.
  assign accept   = in_valid  && (state != TWO);
  assign transfer = out_ready && (state != EMPTY);

  // Channel selected by the current request.
  always_comb begin
    new_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (sel == SELW'(k)) new_data = din[k*WIDTH +: WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Next-state logic; flush overrides any same-cycle accept/transfer.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (accept && !transfer)      state_next = TWO;
        else if (!accept && transfer) state_next = EMPTY;
      end
      TWO:     if (transfer) state_next = ONE;
      default: state_next = EMPTY;
    endcase
    if (flush) state_next = EMPTY;
  end

  // Output decode of the registered state.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    count     = 2'd0;
    case (state)
      ONE: begin
        out_valid = 1'b1;
        count     = 2'd1;
      end
      TWO: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        count     = 2'd2;
      end
      default: ;
    endcase
  end

  // Entry storage: main drives dout/out_sel and keeps its value when drained
  // or flushed; skid holds the second entry in FIFO order.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      out_sel   <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else if (!flush) begin
      case (state)
        EMPTY: begin
          if (accept) begin
            dout    <= new_data;
            out_sel <= sel;
          end
        end
        ONE: begin
          if (accept && transfer) begin
            dout    <= new_data;
            out_sel <= sel;
          end else if (accept) begin
            skid_data <= new_data;
            skid_sel  <= sel;
          end
        end
        TWO: begin
          if (transfer) begin
            dout    <= skid_data;
            out_sel <= skid_sel;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed bench for mux_pipe_n (WIDTH=32, SELW=2). Inputs change and outputs
// are sampled on the falling edge, half a cycle away from the active edge.
module tb_mux_pipe_n;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SELW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [SELW-1:0]    sel;
  logic [4*WIDTH-1:0] din;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   dout;
  logic [SELW-1:0]    out_sel;
  logic [1:0]         count;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  mux_pipe_n #(.WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .din      (din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .out_sel  (out_sel),
    .count    (count)
  );

  always #5 clk = ~clk;

  // One rising edge, then return to the falling edge for checking/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  localparam logic [4*WIDTH-1:0] DIN_STD =
    {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; sel = '0; din = DIN_STD; out_ready = 1'b0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_dout",      64'(dout),      64'h0);
    chk("rst_out_sel",   64'(out_sel),   64'd0);

    // Single request for channel 2
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd2;
    step();
    in_valid = 1'b0;
    chk("single_dout",      64'(dout),      64'h2222_2222);
    chk("single_out_sel",   64'(out_sel),   64'd2);
    chk("single_out_valid", 64'(out_valid), 64'd1);
    chk("single_count",     64'(count),     64'd1);
    step();
    chk("single_drain_valid", 64'(out_valid), 64'd0);
    chk("single_drain_dout",  64'(dout),      64'h2222_2222);
    chk("single_drain_sel",   64'(out_sel),   64'd2);

    // Back-to-back stream, one accept and one transfer per cycle
    in_valid = 1'b1;
    sel = 2'd0; step();
    chk("stream0_dout", 64'(dout), 64'h0000_0000);
    chk("stream0_rdy",  64'(in_ready), 64'd1);
    sel = 2'd1; step();
    chk("stream1_dout", 64'(dout), 64'h1111_1111);
    chk("stream1_rdy",  64'(in_ready), 64'd1);
    sel = 2'd2; step();
    chk("stream2_dout", 64'(dout), 64'h2222_2222);
    chk("stream2_cnt",  64'(count), 64'd1);
    sel = 2'd3; step();
    chk("stream3_dout", 64'(dout), 64'h3333_3333);
    chk("stream3_rdy",  64'(in_ready), 64'd1);
    in_valid = 1'b0;
    step();
    chk("stream_end_valid", 64'(out_valid), 64'd0);

    // Backpressure: fill to TWO, hold, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3;
    step();
    chk("bp_one_cnt",  64'(count), 64'd1);
    chk("bp_one_dout", 64'(dout),  64'h3333_3333);
    sel = 2'd1;
    step();
    in_valid = 1'b0;
    chk("bp_two_cnt",  64'(count),    64'd2);
    chk("bp_two_rdy",  64'(in_ready), 64'd0);
    chk("bp_two_dout", 64'(dout),     64'h3333_3333);
    chk("bp_two_sel",  64'(out_sel),  64'd3);
    in_valid = 1'b1; sel = 2'd0;   // not accepted while full
    step();
    in_valid = 1'b0;
    chk("bp_hold_dout",  64'(dout),      64'h3333_3333);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_cnt",   64'(count),     64'd2);
    out_ready = 1'b1;
    step();
    chk("bp_pop_dout", 64'(dout),     64'h1111_1111);
    chk("bp_pop_sel",  64'(out_sel),  64'd1);
    chk("bp_pop_cnt",  64'(count),    64'd1);
    chk("bp_pop_rdy",  64'(in_ready), 64'd1);
    step();
    chk("bp_empty_valid", 64'(out_valid), 64'd0);
    chk("bp_empty_dout",  64'(dout),      64'h1111_1111);

    // Flush in TWO with accept and transfer in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    step();
    sel = 2'd2;
    step();
    chk("fl_pre_cnt", 64'(count), 64'd2);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; sel = 2'd3;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_cnt",   64'(count),     64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_rdy",   64'(in_ready),  64'd1);
    chk("fl_dout",  64'(dout),      64'h0000_0000);
    chk("fl_sel",   64'(out_sel),   64'd0);
    step();
    chk("fl_after_valid", 64'(out_valid), 64'd0);

    // Captured data is independent of later din changes
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    step();
    in_valid = 1'b0;
    din[63:32] = 32'hDEAD_BEEF;
    step();
    chk("cap_dout0", 64'(dout), 64'h1111_1111);
    step();
    chk("cap_dout1", 64'(dout), 64'h1111_1111);
    out_ready = 1'b1;
    step();
    chk("cap_drain_valid", 64'(out_valid), 64'd0);
    chk("cap_drain_dout",  64'(dout),      64'h1111_1111);
    din = DIN_STD;

    // Reset mid-operation from TWO, with in_valid high
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3;
    step();
    step();
    chk("mid_pre_cnt", 64'(count), 64'd2);
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("mid_rst_cnt",   64'(count),     64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_rdy",   64'(in_ready),  64'd1);
    chk("mid_rst_dout",  64'(dout),      64'h0);
    chk("mid_rst_sel",   64'(out_sel),   64'd0);

    // Normal operation resumes after reset
    in_valid = 1'b1; sel = 2'd3;
    step();
    in_valid = 1'b0;
    chk("post_rst_dout",  64'(dout),      64'h3333_3333);
    chk("post_rst_valid", 64'(out_valid), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mux_pipe_n.md
MUX_PIPE_N -- requirements
Module: mux_pipe_n

Interface
REQ-001 Parameter WIDTH, default 32, data width of each input channel and of the output in bits.
REQ-002 Parameter SELW, default 2, select width; channel count N = 2**SELW, so N = 4 by default.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  producer presents a selection request.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 sel  input  SELW  channel index for the request.
REQ-009 din  input  N*WIDTH  packed channels; channel k = din[k*WIDTH +: WIDTH].
REQ-010 out_valid  output  1  dout/out_sel hold a valid entry.
REQ-011 out_ready  input  1  consumer takes the entry this cycle.
REQ-012 dout  output  WIDTH  selected data of the head entry.
REQ-013 out_sel  output  SELW  sel value captured with the head entry.
REQ-014 count  output  2  entries held, 0..2.

Function
REQ-015 Accept occurs when in_valid && in_ready at a rising edge; the block captures the channel din[sel] and sel at that edge; the captured values do not depend on din or sel in any later cycle.
REQ-016 Transfer occurs when out_valid && out_ready at a rising edge.
REQ-017 Storage is a 2-entry skid buffer: main (drives dout/out_sel) and skid; FIFO order is preserved.
REQ-018 States: EMPTY (count 0), ONE (count 1), TWO (count 2); out_valid = (state != EMPTY).
REQ-019 in_ready is a registered output, equal to 1 in EMPTY and ONE and 0 in TWO.
REQ-020 EMPTY: accept -> ONE with main = new entry; no accept -> stays EMPTY.
REQ-021 ONE: accept with transfer -> ONE with main = new entry; accept without transfer -> TWO with skid = new entry; transfer without accept -> EMPTY; neither -> ONE, main held.
REQ-022 TWO: transfer -> ONE with main = skid; no transfer -> TWO, both entries held; no accept is possible.
REQ-023 Latency: an entry accepted at edge t is visible on dout with out_valid = 1 after edge t when the buffer was EMPTY, or once it reaches main otherwise.
REQ-024 Throughput: with out_ready held at 1, one accept and one transfer occur every cycle.
REQ-025 While out_valid = 1 and out_ready = 0, dout, out_sel and out_valid are held stable.
REQ-026 When the buffer drains to EMPTY, dout and out_sel keep their last values, and out_valid = 0.
REQ-027 flush = 1 at an edge -> state EMPTY, count 0, in_ready 1, out_valid 0; any accept or transfer in that same cycle is discarded; dout/out_sel are held.
REQ-028 No combinational path from out_ready to in_ready.
REQ-029 All sel values 0..N-1 are legal; there is no out-of-range case.

Reset
REQ-030 rst = 1 at an edge -> state EMPTY, count 0, out_valid 0, in_ready 1, dout all zeros, out_sel 0.
REQ-031 rst has priority over flush, accept and transfer.
REQ-032 rst asserted mid-operation in any state discards all entries; with rst = 1, in_valid is ignored.

Verification (WIDTH=32, SELW=2)
REQ-033 Reset, then check outputs: out_valid=0, in_ready=1, count=0, dout=0x00000000, out_sel=0.
REQ-034 din={0x33333333,0x22222222,0x11111111,0x00000000}, sel=2'b10, in_valid=1 for one cycle, out_ready=1 -> next cycle dout=0x22222222, out_sel=2, out_valid=1; cycle after that out_valid=0.
REQ-035 Stream sel=0,1,2,3 on consecutive cycles with out_ready=1 -> dout=0x00000000, 0x11111111, 0x22222222, 0x33333333 on consecutive cycles; in_ready stays 1.
REQ-036 out_ready=0, accept sel=3 then sel=1 -> count=2, in_ready=0, dout=0x33333333 held; raise out_ready -> dout=0x11111111 next cycle, then out_valid=0.
REQ-037 In TWO state, assert flush together with out_ready=1 and in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, and nothing from that cycle appears at the output.
REQ-038 Change din after accept (sel=1, then din channel 1 = 0xDEADBEEF, out_ready=0) -> dout stays 0x11111111 until transfer.
